// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, per-unit multicycle handshake FSMs,
// memory stall / exception arbitration. Optional counters built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned N_MC      = 2,
    parameter logic [31:0] ERET_CODE = 32'h0000_000e
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            ex_rmem,
    input  logic            mem_rmem,
    input  logic [4:0]      ex_rt,
    input  logic [4:0]      mem_rt,
    input  logic            id_jb_stall,
    input  logic [N_MC-1:0] mc_req,
    input  logic [N_MC-1:0] mc_ready,
    output logic [N_MC-1:0] mc_start,
    output logic [N_MC-1:0] mc_cancel,
    input  logic            stallreq_if,
    input  logic            stallreq_mem,
    input  logic [31:0]     mem_excepttype,
    input  logic [31:0]     mem_cp0_epc,
    input  logic            bev,
    input  logic [31:0]     ebase,
    output logic            if_stall,
    output logic            id_stall,
    output logic            ex_stall,
    output logic            mem_stall,
    output logic            wb_stall,
    output logic            if_flush,
    output logic            id_flush,
    output logic            ex_flush,
    output logic            mem_flush,
    output logic            wb_flush,
    output logic [31:0]     mem_newpc,
    output logic [31:0]     perf_lw,
    output logic [31:0]     perf_mc,
    output logic [31:0]     perf_flush
);

    localparam logic [31:0] BEV_VECTOR = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    logic            lw_stall;
    logic            mem_busy;
    logic            exc;
    logic            flush_fire;
    logic            mc_stall;
    logic            back;
    logic [N_MC-1:0] unit_stall;
    logic            unused_ebase;

    // $0 as a load destination never creates a dependency
    assign lw_stall = (ex_rmem  && (ex_rt  != 5'd0) && ((ex_rt  == id_rs) || (ex_rt  == id_rt)))
                   || (mem_rmem && (mem_rt != 5'd0) && ((mem_rt == id_rs) || (mem_rt == id_rt)));

    assign mem_busy   = stallreq_if || stallreq_mem;
    assign exc        = (mem_excepttype != 32'd0);
    assign flush_fire = exc && !mem_busy;

    for (genvar g = 0; g < N_MC; g++) begin : g_mc
        mc_state_e state_q;
        mc_state_e state_d;
        logic      start_c;
        logic      cancel_c;
        logic      stall_c;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= MC_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                MC_IDLE: if (mc_req[g] && !flush_fire) state_d = MC_BUSY;
                MC_BUSY: begin
                    if (flush_fire)        state_d = MC_IDLE;
                    else if (mc_ready[g])  state_d = MC_DONE;
                end
                MC_DONE: state_d = MC_IDLE;
                default: state_d = MC_IDLE;
            endcase
        end

        // Start is Mealy so the unit begins in the same cycle EX presents the op
        always_comb begin
            start_c  = 1'b0;
            cancel_c = 1'b0;
            stall_c  = 1'b0;
            case (state_q)
                MC_IDLE: begin
                    start_c = mc_req[g] && !flush_fire;
                    stall_c = mc_req[g];
                end
                MC_BUSY: begin
                    stall_c  = 1'b1;
                    cancel_c = flush_fire;
                end
                MC_DONE: cancel_c = flush_fire;
                default: ;
            endcase
        end

        assign mc_start[g]   = start_c;
        assign mc_cancel[g]  = cancel_c;
        assign unit_stall[g] = stall_c;
    end

    assign mc_stall = |unit_stall;
    assign back     = mc_stall || mem_busy;

    assign wb_stall  = back;
    assign mem_stall = back;
    assign ex_stall  = back;
    assign id_stall  = back || lw_stall || id_jb_stall;
    assign if_stall  = id_stall && !if_flush;

    assign if_flush  = flush_fire;
    assign id_flush  = flush_fire;
    assign mem_flush = flush_fire;
    assign wb_flush  = flush_fire;
    // Bubble into EX when ID holds but the back end keeps moving
    assign ex_flush  = flush_fire || ((lw_stall || id_jb_stall) && !back);

    always_comb begin
        mem_newpc = 32'd0;
        if (exc) begin
            if (mem_excepttype == ERET_CODE) mem_newpc = mem_cp0_epc;
            else if (bev)                    mem_newpc = BEV_VECTOR;
            else                             mem_newpc = {ebase[31:12], 12'h180};
        end
    end

    assign unused_ebase = ^ebase[11:0];

`ifdef HAZARD_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] lw_cnt_q;
    logic [CNT_W-1:0] mc_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lw_cnt_q    <= '0;
            mc_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lw_stall && !back && (lw_cnt_q != '1)) lw_cnt_q <= lw_cnt_q + CNT_W'(1);
            if (mc_stall && (mc_cnt_q != '1))          mc_cnt_q <= mc_cnt_q + CNT_W'(1);
            if (flush_fire && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign perf_lw    = lw_cnt_q;
    assign perf_mc    = mc_cnt_q;
    assign perf_flush = flush_cnt_q;
`else
    assign perf_lw    = 32'd0;
    assign perf_mc    = 32'd0;
    assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned N_MC = 2;
    localparam logic [31:0] ERET = 32'h0000_000e;

    logic            clk = 1'b0;
    logic            resetn;
    logic [4:0]      id_rs, id_rt, ex_rt, mem_rt;
    logic            ex_rmem, mem_rmem, id_jb_stall;
    logic [N_MC-1:0] mc_req, mc_ready, mc_start, mc_cancel;
    logic            stallreq_if, stallreq_mem, bev;
    logic [31:0]     mem_excepttype, mem_cp0_epc, ebase, mem_newpc;
    logic            if_stall, id_stall, ex_stall, mem_stall, wb_stall;
    logic            if_flush, id_flush, ex_flush, mem_flush, wb_flush;
    logic [31:0]     perf_lw, perf_mc, perf_flush;

    int checks = 0;
    int errors = 0;
    int n_exstall = 0;
    int n_start0 = 0;

    // Model: op issued and awaiting result / result delivered this cycle
    bit          m_wait [N_MC];
    bit          m_got  [N_MC];
    logic [31:0] m_plw, m_pmc, m_pfl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.N_MC(N_MC), .ERET_CODE(ERET)) dut (
        .clk(clk), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rmem(ex_rmem), .mem_rmem(mem_rmem), .ex_rt(ex_rt), .mem_rt(mem_rt),
        .id_jb_stall(id_jb_stall), .mc_req(mc_req), .mc_ready(mc_ready),
        .mc_start(mc_start), .mc_cancel(mc_cancel),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc), .bev(bev), .ebase(ebase),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .wb_stall(wb_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
        .mem_flush(mem_flush), .wb_flush(wb_flush), .mem_newpc(mem_newpc),
        .perf_lw(perf_lw), .perf_mc(perf_mc), .perf_flush(perf_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_MC; i++) begin
            m_wait[i] = 1'b0;
            m_got[i]  = 1'b0;
        end
        m_plw = 32'd0;
        m_pmc = 32'd0;
        m_pfl = 32'd0;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; mem_rt = 5'd0;
        ex_rmem = 1'b0; mem_rmem = 1'b0; id_jb_stall = 1'b0;
        mc_req = '0; mc_ready = '0; stallreq_if = 1'b0; stallreq_mem = 1'b0;
        mem_excepttype = 32'd0; mem_cp0_epc = 32'd0; bev = 1'b0; ebase = 32'h8000_0000;
    endtask

    // One cycle: let inputs settle, compare every output with the model, then advance the model
    task automatic step(input string tag);
        bit lw, busy, exc, ff, mcs, back, ids;
        logic [N_MC-1:0] es, ec;
        logic [31:0] npc;
        #1;
        lw = (ex_rmem && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt))
          || (mem_rmem && mem_rt != 0 && (mem_rt == id_rs || mem_rt == id_rt));
        busy = stallreq_if || stallreq_mem;
        exc  = mem_excepttype != 0;
        ff   = exc && !busy;
        mcs  = 1'b0;
        for (int i = 0; i < N_MC; i++) begin
            bit free;
            free  = !m_wait[i] && !m_got[i];
            es[i] = free && mc_req[i] && !ff;
            ec[i] = !free && ff;
            if (m_wait[i] || (free && mc_req[i])) mcs = 1'b1;
        end
        back = mcs || busy;
        ids  = back || lw || id_jb_stall;
        if (!exc)                npc = 32'd0;
        else if (mem_excepttype == ERET) npc = mem_cp0_epc;
        else if (bev)            npc = 32'hbfc0_0380;
        else                     npc = {ebase[31:12], 12'h180};

        chk({tag, ".mc_start"},  32'(mc_start),  32'(es));
        chk({tag, ".mc_cancel"}, 32'(mc_cancel), 32'(ec));
        chk({tag, ".stalls"}, 32'({if_stall, id_stall, ex_stall, mem_stall, wb_stall}),
            32'({ids && !ff, ids, back, back, back}));
        chk({tag, ".flushes"}, 32'({if_flush, id_flush, ex_flush, mem_flush, wb_flush}),
            32'({ff, ff, ff || ((lw || id_jb_stall) && !back), ff, ff}));
        chk({tag, ".newpc"}, mem_newpc, npc);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".perf_lw"}, perf_lw, m_plw);
        chk({tag, ".perf_mc"}, perf_mc, m_pmc);
        chk({tag, ".perf_flush"}, perf_flush, m_pfl);
`else
        chk({tag, ".perf"}, perf_lw | perf_mc | perf_flush, 32'd0);
`endif
        if (ex_stall) n_exstall++;
        if (mc_start[0]) n_start0++;

        @(posedge clk);
        if (resetn) begin
            for (int i = 0; i < N_MC; i++) begin
                if (m_wait[i]) begin
                    if (ff) m_wait[i] = 1'b0;
                    else if (mc_ready[i]) begin
                        m_wait[i] = 1'b0;
                        m_got[i]  = 1'b1;
                    end
                end else if (m_got[i]) begin
                    m_got[i] = 1'b0;
                end else if (es[i]) begin
                    m_wait[i] = 1'b1;
                end
            end
            if (lw && !back && m_plw != 32'hffff_ffff) m_plw++;
            if (mcs && m_pmc != 32'hffff_ffff)         m_pmc++;
            if (ff && m_pfl != 32'hffff_ffff)          m_pfl++;
        end
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_model();
        step("reset0");
        step("reset1");
        resetn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b1;
        clear_model();
        #2;
        do_reset();

        // Load-use on rs, then same with $0 destination
        ex_rmem = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lw.id_stall", 32'(id_stall), 32'd1);
        chk("lw.ex_flush", 32'(ex_flush), 32'd1);
        chk("lw.ex_stall", 32'(ex_stall), 32'd0);
        step("lw");
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lw0.id_stall", 32'(id_stall), 32'd0);
        step("lw0");
        mem_rmem = 1'b1; mem_rt = 5'd7; id_rt = 5'd7; ex_rmem = 1'b0;
        step("lw_mem");
        idle_inputs();

        // Divider: result after 32 busy cycles
        n_exstall = 0; n_start0 = 0;
        mc_req[0] = 1'b1;
        for (int c = 0; c < 36; c++) begin
            mc_ready[0] = (c == 32);
            if (c == 34) mc_req[0] = 1'b0;
            step("div");
        end
        chk("div.ex_stall_cycles", 32'(n_exstall), 32'd33);
        chk("div.start_pulses", 32'(n_start0), 32'd1);

        // Exception while div busy: cancel and redirect to BEV vector
        mc_req[0] = 1'b1;
        step("exc_start");
        step("exc_busy");
        mem_excepttype = 32'h4; bev = 1'b1;
        #1;
        chk("exc.cancel", 32'(mc_cancel), 32'd1);
        chk("exc.newpc", mem_newpc, 32'hbfc0_0380);
        step("exc_fire");
        idle_inputs();
        n_start0 = 0;
        for (int c = 0; c < 3; c++) step("exc_after");
        chk("exc.no_restart", 32'(n_start0), 32'd0);

        // ERET held under a D-side stall for three cycles
        mem_excepttype = ERET; mem_cp0_epc = 32'h8000_1234; stallreq_mem = 1'b1;
        for (int c = 0; c < 3; c++) step("eret_hold");
        stallreq_mem = 1'b0;
        #1;
        chk("eret.if_flush", 32'(if_flush), 32'd1);
        chk("eret.newpc", mem_newpc, 32'h8000_1234);
        step("eret_fire");
        idle_inputs();

        // Both units at once, mult finishes first
        mc_req = 2'b11;
        for (int c = 0; c < 24; c++) begin
            mc_ready = {c == 5, c == 20};
            if (c == 7)  mc_req[1] = 1'b0;
            if (c == 22) mc_req[0] = 1'b0;
            step("dual");
        end
        idle_inputs();

        // Reset mid-busy with an exception present: no cancel allowed
        mc_req[0] = 1'b1;
        step("rst_start");
        step("rst_busy");
        mem_excepttype = 32'h20;
        do_reset();
        idle_inputs();
        step("rst_after");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            mem_rt = 5'($urandom_range(0, 3));
            ex_rmem = ($urandom_range(0, 2) == 0);
            mem_rmem = ($urandom_range(0, 2) == 0);
            id_jb_stall = ($urandom_range(0, 7) == 0);
            mc_req = N_MC'($urandom_range(0, 3));
            mc_ready = N_MC'($urandom_range(0, 3)) & N_MC'($urandom_range(0, 3));
            stallreq_if = ($urandom_range(0, 5) == 0);
            stallreq_mem = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 11))
                0:       mem_excepttype = ERET;
                1:       mem_excepttype = 32'($urandom_range(1, 31));
                default: mem_excepttype = 32'd0;
            endcase
            mem_cp0_epc = $urandom;
            bev = 1'($urandom_range(0, 1));
            ebase = $urandom;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
